// File: rtl/ransac_sample_picker.sv
// Draws SAMPLE_COUNT distinct indices below point_count; optional RANSAC_SAMPLE_PICKER_TIMEOUT_EN caps rejections.
// Latency SAMPLE_COUNT+1 cycles from start plus one per rejected draw; result held in HOLD until sample_ready.
module ransac_sample_picker #(
  parameter int INDEX_WIDTH  = 16,
  parameter int SAMPLE_COUNT = 2
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [63:0]                         random_value,
  input  logic [INDEX_WIDTH-1:0]              point_count,
  input  logic                                start,
  output logic                                busy,
  output logic                                sample_valid,
  input  logic                                sample_ready,
  output logic [SAMPLE_COUNT*INDEX_WIDTH-1:0] sample_indices,
  output logic                                sample_error
);

  localparam int SLOT_W = $clog2(SAMPLE_COUNT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                   state;
  logic [SLOT_W-1:0]        slot_cnt;
  logic [INDEX_WIDTH-1:0]   latched_count;
  logic [INDEX_WIDTH-1:0]   slot_q [SAMPLE_COUNT];
  logic [2*INDEX_WIDTH-1:0] product;
  logic [INDEX_WIDTH-1:0]   candidate;
  logic                     duplicate;
  logic                     last_slot;
  logic                     count_ok;
  logic                     unused_bits;
`ifdef RANSAC_SAMPLE_PICKER_TIMEOUT_EN
  logic [7:0]               attempt_cnt;
`endif

  // Scaling by the full-width product keeps the candidate strictly below latched_count.
  assign product     = {{INDEX_WIDTH{1'b0}}, random_value[INDEX_WIDTH-1:0]}
                     * {{INDEX_WIDTH{1'b0}}, latched_count};
  assign candidate   = product[2*INDEX_WIDTH-1:INDEX_WIDTH];
  assign unused_bits = ^{random_value[63:INDEX_WIDTH], product[INDEX_WIDTH-1:0]};
  assign last_slot   = (slot_cnt == SLOT_W'(SAMPLE_COUNT - 1));
  assign count_ok    = (point_count >= INDEX_WIDTH'(SAMPLE_COUNT));

  always_comb begin
    duplicate = 1'b0;
    for (int k = 0; k < SAMPLE_COUNT; k++) begin
      if ((SLOT_W'(k) < slot_cnt) && (slot_q[k] == candidate)) begin
        duplicate = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < SAMPLE_COUNT; g++) begin : g_pack
    assign sample_indices[g*INDEX_WIDTH +: INDEX_WIDTH] = slot_q[g];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      sample_valid  <= 1'b0;
      sample_error  <= 1'b0;
      slot_cnt      <= '0;
      latched_count <= '0;
      for (int k = 0; k < SAMPLE_COUNT; k++) slot_q[k] <= '0;
`ifdef RANSAC_SAMPLE_PICKER_TIMEOUT_EN
      attempt_cnt   <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < SAMPLE_COUNT; k++) slot_q[k] <= '0;
            busy <= 1'b1;
            if (count_ok) begin
              latched_count <= point_count;
              slot_cnt      <= '0;
`ifdef RANSAC_SAMPLE_PICKER_TIMEOUT_EN
              attempt_cnt   <= 8'd0;
`endif
              state         <= DRAW;
            end else begin
              sample_valid <= 1'b1;
              sample_error <= 1'b1;
              state        <= HOLD;
            end
          end
        end
        DRAW: begin
          if (duplicate) begin
`ifdef RANSAC_SAMPLE_PICKER_TIMEOUT_EN
            // Give up after 256 consecutive rejections; filled slots are reported as-is.
            if (attempt_cnt == 8'd255) begin
              sample_valid <= 1'b1;
              sample_error <= 1'b1;
              state        <= HOLD;
            end else begin
              attempt_cnt <= attempt_cnt + 8'd1;
            end
`endif
          end else begin
            for (int k = 0; k < SAMPLE_COUNT; k++) begin
              if (SLOT_W'(k) == slot_cnt) slot_q[k] <= candidate;
            end
            if (last_slot) begin
              sample_valid <= 1'b1;
              sample_error <= 1'b0;
              state        <= HOLD;
            end else begin
              slot_cnt <= slot_cnt + SLOT_W'(1);
            end
          end
        end
        HOLD: begin
          if (sample_ready) begin
            busy         <= 1'b0;
            sample_valid <= 1'b0;
            sample_error <= 1'b0;
            state        <= IDLE;
          end
        end
        default: begin
          busy         <= 1'b0;
          sample_valid <= 1'b0;
          sample_error <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ransac_sample_picker.sv
// Randomized and directed checks of ransac_sample_picker against a queue-based reference model.
module tb_ransac_sample_picker;
  localparam int IW = 16;
  localparam int SC = 2;

  logic           clock = 1'b0;
  logic           reset;
  logic [63:0]    random_value;
  logic [IW-1:0]  point_count;
  logic           start;
  logic           busy;
  logic           sample_valid;
  logic           sample_ready;
  logic [SC*IW-1:0] sample_indices;
  logic           sample_error;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] rq[$];

  always #5 clock = ~clock;

  ransac_sample_picker #(.INDEX_WIDTH(IW), .SAMPLE_COUNT(SC)) dut (
    .clock(clock), .reset(reset), .random_value(random_value),
    .point_count(point_count), .start(start), .busy(busy),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_indices(sample_indices), .sample_error(sample_error)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Reference: consume random words in order, scale into [0,pc), keep distinct ones.
  task automatic model(input int pc, output logic [SC*IW-1:0] exp_vec, output int used, output bit err);
    longint filled[$];
    longint c;
    bit dup;
    int rejects;
    exp_vec = '0;
    used    = 0;
    err     = 0;
    rejects = 0;
    if (pc < SC) begin
      err = 1;
      return;
    end
    while (filled.size() < SC && used < rq.size()) begin
      c = (longint'(rq[used] & 64'hFFFF) * longint'(pc)) >> IW;
      used++;
      dup = 0;
      foreach (filled[j]) if (filled[j] == c) dup = 1;
      if (dup) begin
        rejects++;
`ifdef RANSAC_SAMPLE_PICKER_TIMEOUT_EN
        if (rejects == 256) break;
`endif
      end else begin
        filled.push_back(c);
      end
    end
    if (filled.size() < SC) err = 1;
    foreach (filled[k]) exp_vec[k*IW +: IW] = IW'(filled[k]);
  endtask

  task automatic do_request(input string tag, input int pc, input int hold);
    logic [SC*IW-1:0] exp_vec;
    int used;
    bit err;
    int cycles;
    int qi;
    model(pc, exp_vec, used, err);
    start        = 1'b1;
    point_count  = IW'(pc);
    random_value = {$urandom, $urandom};
    tick;
    start  = 1'b0;
    cycles = 1;
    qi     = 0;
    while (!sample_valid && cycles < 600) begin
      random_value = (qi < rq.size()) ? rq[qi] : {$urandom, $urandom};
      qi++;
      tick;
      cycles++;
    end
    check_eq({tag, " latency"}, 64'(cycles), 64'(1 + used));
    check_eq({tag, " valid"}, 64'(sample_valid), 64'd1);
    check_eq({tag, " error"}, 64'(sample_error), 64'(err));
    check_eq({tag, " indices"}, 64'(sample_indices), 64'(exp_vec));
    for (int i = 0; i < hold; i++) begin
      start        = (i == 1);
      point_count  = IW'($urandom_range(2, 50));
      random_value = {$urandom, $urandom};
      tick;
      start = 1'b0;
      check_eq({tag, " hold valid"}, 64'(sample_valid), 64'd1);
      check_eq({tag, " hold indices"}, 64'(sample_indices), 64'(exp_vec));
    end
    sample_ready = 1'b1;
    tick;
    sample_ready = 1'b0;
    check_eq({tag, " drop valid"}, 64'(sample_valid), 64'd0);
    check_eq({tag, " idle busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    sample_ready = 1'b0;
    random_value = '0;
    point_count  = '0;
    tick;
    tick;
    check_eq("reset busy", 64'(busy), 64'd0);
    check_eq("reset valid", 64'(sample_valid), 64'd0);
    check_eq("reset error", 64'(sample_error), 64'd0);
    check_eq("reset indices", 64'(sample_indices), 64'd0);
    reset = 1'b0;
    tick;

    rq = {};
    do_request("too_few", 1, 0);
    rq = {};
    do_request("zero_points", 0, 0);
    rq = {64'h0000, 64'h8000};
    do_request("two_draws", 100, 0);
    rq = {64'h8000, 64'h8000, 64'hC000};
    do_request("reject", 100, 0);
    rq = {64'hFFFF_0000_0000_1000, 64'h9000};
    do_request("backpressure", 100, 5);

    // Reset during the second DRAW cycle discards the partial set.
    start        = 1'b1;
    point_count  = IW'(100);
    tick;
    start        = 1'b0;
    random_value = 64'h4000;
    tick;
    random_value = 64'h8000;
    reset        = 1'b1;
    tick;
    reset        = 1'b0;
    check_eq("mid_reset busy", 64'(busy), 64'd0);
    check_eq("mid_reset valid", 64'(sample_valid), 64'd0);
    check_eq("mid_reset indices", 64'(sample_indices), 64'd0);
    rq = {64'h4000, 64'h8000};
    do_request("after_reset", 100, 1);

`ifdef RANSAC_SAMPLE_PICKER_TIMEOUT_EN
    rq = {};
    for (int i = 0; i < 300; i++) rq.push_back(64'h8000);
    do_request("timeout", 100, 0);
`endif

    for (int t = 0; t < 25; t++) begin
      rq = {};
      for (int i = 0; i < 40; i++) rq.push_back({$urandom, $urandom});
      do_request($sformatf("rand%0d", t), $urandom_range(0, 9), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ransac_sample_picker.md
RANSAC_SAMPLE_PICKER -- requirements
Module: ransac_sample_picker

Interface
REQ-001 SHALL have parameter INDEX_WIDTH, default 16: bit width of one point index (legal range 4..32).
REQ-002 SHALL have parameter SAMPLE_COUNT, default 2: number of distinct indices drawn per request (legal range 2..4).
REQ-003 SHALL have port clock  input  1  the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port random_value  input  64  random word from the lfsr output; only bits [INDEX_WIDTH-1:0] are used.
REQ-006 SHALL have port point_count  input  INDEX_WIDTH  number of points in the data set; sampled on start acceptance.
REQ-007 SHALL have port start  input  1  request for a new sample set.
REQ-008 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-009 SHALL have port sample_valid  output  1  sample set is available.
REQ-010 SHALL have port sample_ready  input  1  consumer accepts the sample set.
REQ-011 SHALL have port sample_indices  output  SAMPLE_COUNT*INDEX_WIDTH  slot k occupies bits [k*INDEX_WIDTH +: INDEX_WIDTH].
REQ-012 SHALL have port sample_error  output  1  sample set is invalid; qualified by sample_valid.

Function
REQ-013 SHALL implement the states IDLE, DRAW and HOLD.
REQ-014 In IDLE, start=1 with point_count >= SAMPLE_COUNT SHALL latch point_count, clear the slot counter and enter DRAW.
REQ-015 In IDLE, start=1 with point_count < SAMPLE_COUNT SHALL enter HOLD with sample_error=1 and all indices set to 0.
REQ-016 start SHALL be ignored in DRAW and HOLD.
REQ-017 Each DRAW cycle SHALL form candidate = (random_value[INDEX_WIDTH-1:0] * latched_count) >> INDEX_WIDTH.
  - The product is full width (2*INDEX_WIDTH), so candidate < latched_count always.
REQ-018 A candidate equal to any already-filled slot SHALL be rejected: no slot is written and the slot counter is held.
REQ-019 A candidate that is not rejected SHALL be written to the current slot, and the slot counter SHALL increment.
REQ-020 After slot SAMPLE_COUNT-1 is written, the next state SHALL be HOLD with sample_error=0.
REQ-021 In HOLD, sample_valid=1, and sample_indices and sample_error SHALL be held stable until sample_ready=1.
REQ-022 sample_valid=1 together with sample_ready=1 SHALL complete the transfer; the next state is IDLE and sample_valid drops on the following cycle.
REQ-023 Minimum latency: sample_valid SHALL assert SAMPLE_COUNT+1 cycles after the start edge; each rejected candidate adds one cycle.
REQ-024 The duplicate comparison SHALL be combinational against the filled slots only; unfilled slots never cause a rejection.

Reset
REQ-025 reset=1 SHALL, at the next rising edge, force state IDLE, busy=0, sample_valid=0, sample_error=0, sample_indices=0, the slot counter to 0 and the attempt counter to 0.
REQ-026 Reset SHALL take priority over all other inputs, including mid-DRAW and mid-HOLD; any partial sample set is discarded.

Configuration
REQ-027 SHALL support the macro RANSAC_SAMPLE_PICKER_TIMEOUT_EN.
REQ-028 With RANSAC_SAMPLE_PICKER_TIMEOUT_EN defined:
  - an 8-bit attempt counter SHALL be cleared on start acceptance and incremented on each rejection;
  - a rejection with the counter at 255 SHALL enter HOLD with sample_error=1, and filled slots keep their values.
REQ-029 Without RANSAC_SAMPLE_PICKER_TIMEOUT_EN, no attempt counter SHALL exist, and DRAW SHALL continue until all slots are filled.

Verification
REQ-030 SAMPLE_COUNT=2, point_count=1, start pulse -> next cycle sample_valid=1, sample_error=1, sample_indices=0.
REQ-031 point_count=100, random low bits 16'h0000 then 16'h8000 -> indices {0,50}, sample_error=0, sample_valid at cycle 3 after start.
REQ-032 point_count=100, random low bits 16'h8000, 16'h8000, 16'hC000 -> second draw rejected, indices {50,75}, sample_valid at cycle 4.
REQ-033 Backpressure: sample_ready=0 for 5 cycles in HOLD, with start pulsed -> sample_valid and indices stable and start ignored; sample_ready=1 -> IDLE next cycle.
REQ-034 reset=1 in the second DRAW cycle -> next cycle busy=0 and sample_valid=0; a new start then completes normally.
REQ-035 RANSAC_SAMPLE_PICKER_TIMEOUT_EN defined, random low bits stuck at 16'h8000, point_count=100 -> after 256 rejections sample_valid=1, sample_error=1, slot0=50.
